// File: rtl/counter_pkg.sv
// Shared counter/timer definitions: direction codes, the per-edge operation
// type and the load clamp helper.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_CLR,
    OP_LOAD,
    OP_STEP
  } op_e;

  function automatic logic [31:0] clamp_mod(
    input logic [31:0] value,
    input logic [31:0] modulo
  );
    return (value >= modulo) ? modulo - 32'd1 : value;
  endfunction

endpackage

// File: rtl/up_down_counter_mod_if.sv
// Control and status bundle of the modulo up/down counter.
// The master drives the controls; the slave is the counter itself.
interface up_down_counter_mod_if #(
    parameter int WIDTH = 8
);

    logic             clr;
    logic             en;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             zero;
    logic             tc;
    logic             ovf;

    modport master (
        output clr, en, dir, load, load_val,
        input  count, zero, tc, ovf
    );

    modport slave (
        input  clr, en, dir, load, load_val,
        output count, zero, tc, ovf
    );

endinterface

// File: rtl/en_prescaler.sv
// Enable prescaler: emits one step per PRESCALE qualified en cycles.
// clr_i restarts the phase at 0.
module en_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en,
    output logic step
);

    if (PRESCALE <= 1) begin : g_bypass
        logic unused_ok;
        assign unused_ok = &{1'b0, clk, rst_n, clr_i};
        assign step      = en;
    end else begin : g_div
        localparam int PW = $clog2(PRESCALE);
        localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

        logic [PW-1:0] ps_q;
        logic          wrap;

        assign wrap = (ps_q == LAST);
        assign step = en && wrap;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ps_q <= '0;
            end else if (clr_i) begin
                ps_q <= '0;
            end else if (en) begin
                ps_q <= wrap ? '0 : ps_q + PW'(1);
            end
        end
    end

endmodule

// File: rtl/up_down_counter_mod.sv
// Modulo-N up/down counter with load/clear, wrap or saturate, prescaled
// enable, registered terminal-count pulse and sticky overflow.
module up_down_counter_mod
    import counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MODULO   = 256,
    parameter bit SATURATE = 1'b0,
    parameter int PRESCALE = 1
) (
    input logic                  clk,
    input logic                  rst_n,
    up_down_counter_mod_if.slave bus
);

    localparam logic [WIDTH:0] TOP = (WIDTH + 1)'(MODULO - 1);

    op_e              op;
    logic             step;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] ld_c;
    logic             tc_q;
    logic             tc_d;
    logic             ovf_q;
    logic             ovf_d;
    logic [WIDTH:0]   cnt_x;
    logic [WIDTH:0]   nxt_x;
    logic             up;
    logic             bound;
    logic             unused_msb;

    en_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_ps (
        .clk  (clk),
        .rst_n(rst_n),
        .clr_i(bus.clr | bus.load),
        .en   (bus.en),
        .step (step)
    );

    assign ld_c  = WIDTH'(clamp_mod(32'(bus.load_val), 32'(MODULO)));
    assign up    = (bus.dir == DIR_UP);
    assign cnt_x = {1'b0, count_q};
    assign bound = up ? (cnt_x == TOP) : (cnt_x == '0);

    // One bit of headroom keeps the +1/-1 from aliasing at full width.
    always_comb begin
        nxt_x = cnt_x;
        if (!bound) begin
            nxt_x = up ? cnt_x + 1'b1 : cnt_x - 1'b1;
        end else if (!SATURATE) begin
            nxt_x = up ? '0 : TOP;
        end
    end

    assign unused_msb = nxt_x[WIDTH];

    always_comb begin
        op = OP_HOLD;
        priority case (1'b1)
            bus.clr:  op = OP_CLR;
            bus.load: op = OP_LOAD;
            step:     op = OP_STEP;
            default:  op = OP_HOLD;
        endcase
    end

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;
        unique case (op)
            OP_CLR: begin
                count_d = '0;
                ovf_d   = 1'b0;
            end
            OP_LOAD: begin
                count_d = ld_c;
            end
            OP_STEP: begin
                count_d = nxt_x[WIDTH-1:0];
                tc_d    = bound;
                ovf_d   = ovf_q | bound;
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.count = count_q;
    assign bus.zero  = (count_q == '0);
    assign bus.tc    = tc_q;
    assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_up_down_counter_mod.sv
// Four counter configurations share one stimulus stream and are checked
// every cycle against an integer model, plus directed literal checks.
module tb_up_down_counter_mod;

    localparam int NI = 4;
    localparam int MODS [NI] = '{10, 100, 10, 256};
    localparam int SATS [NI] = '{0, 1, 0, 0};
    localparam int PRES [NI] = '{1, 1, 4, 1};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       en = 1'b0;
    logic       dir = 1'b1;
    logic       load = 1'b0;
    logic [7:0] ld_val = 8'd0;

    logic [7:0] cnt_o  [NI];
    logic       zero_o [NI];
    logic       tc_o   [NI];
    logic       ovf_o  [NI];

    int m_cnt [NI];
    int m_ph  [NI];
    bit m_tc  [NI];
    bit m_ovf [NI];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        up_down_counter_mod_if #(.WIDTH(8)) bus ();

        assign bus.clr      = clr;
        assign bus.en       = en;
        assign bus.dir      = dir;
        assign bus.load     = load;
        assign bus.load_val = ld_val;
        assign cnt_o[g]     = bus.count;
        assign zero_o[g]    = bus.zero;
        assign tc_o[g]      = bus.tc;
        assign ovf_o[g]     = bus.ovf;

        up_down_counter_mod #(
            .WIDTH   (8),
            .MODULO  (MODS[g]),
            .SATURATE(SATS[g] != 0),
            .PRESCALE(PRES[g])
        ) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (bus.slave)
        );
    end

    function automatic bit at_bound(int c, int m, bit up);
        return up ? (c == m - 1) : (c == 0);
    endfunction

    function automatic int after_step(int c, int m, bit up, int sat);
        if (!at_bound(c, m, up)) return up ? c + 1 : c - 1;
        if (sat != 0) return c;
        return up ? 0 : m - 1;
    endfunction

    // m_ph counts en cycles since the last phase restart.
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                m_cnt[i] <= 0;
                m_ph[i]  <= 0;
                m_tc[i]  <= 1'b0;
                m_ovf[i] <= 1'b0;
            end else if (clr) begin
                m_cnt[i] <= 0;
                m_ph[i]  <= 0;
                m_tc[i]  <= 1'b0;
                m_ovf[i] <= 1'b0;
            end else if (load) begin
                m_cnt[i] <= (int'(ld_val) > MODS[i] - 1) ? MODS[i] - 1 : int'(ld_val);
                m_ph[i]  <= 0;
                m_tc[i]  <= 1'b0;
            end else if (en && ((m_ph[i] + 1) % PRES[i] == 0)) begin
                m_cnt[i] <= after_step(m_cnt[i], MODS[i], dir, SATS[i]);
                m_ph[i]  <= 0;
                m_tc[i]  <= at_bound(m_cnt[i], MODS[i], dir);
                if (at_bound(m_cnt[i], MODS[i], dir)) m_ovf[i] <= 1'b1;
            end else begin
                m_tc[i] <= 1'b0;
                if (en) m_ph[i] <= m_ph[i] + 1;
            end
        end
    end

    task automatic chk(input string nm, input int idx, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", nm, idx, $time, got, exp);
    endtask

    task automatic compare_all();
        for (int i = 0; i < NI; i++) begin
            chk("count", i, int'(cnt_o[i]), m_cnt[i]);
            chk("zero", i, int'(zero_o[i]), int'(m_cnt[i] == 0));
            chk("tc", i, int'(tc_o[i]), int'(m_tc[i]));
            chk("ovf", i, int'(ovf_o[i]), int'(m_ovf[i]));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        cyc();
        cyc();
        chk("rst_count", 0, int'(cnt_o[0]), 0);
        chk("rst_zero", 0, int'(zero_o[0]), 1);
        rst_n = 1'b1;
        cyc();

        en = 1'b1;
        dir = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            chk("wrap_count", k, int'(cnt_o[0]), k % 10);
            chk("wrap_tc", k, int'(tc_o[0]), int'(k == 10));
        end
        chk("wrap_p4", 2, int'(cnt_o[2]), 2);
        en = 1'b0;
        cyc();
        chk("wrap_tc_end", 0, int'(tc_o[0]), 0);
        chk("wrap_ovf", 0, int'(ovf_o[0]), 1);

        load = 1'b1;
        ld_val = 8'd2;
        cyc();
        chk("sat_load", 1, int'(cnt_o[1]), 2);
        load = 1'b0;
        dir = 1'b0;
        en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk("sat_count", k, int'(cnt_o[1]), (k == 1) ? 1 : 0);
            chk("sat_tc", k, int'(tc_o[1]), int'(k >= 3));
            chk("sat_ovf", k, int'(ovf_o[1]), int'(k >= 3));
        end

        clr = 1'b1;
        load = 1'b1;
        ld_val = 8'd200;
        cyc();
        for (int i = 0; i < NI; i++) begin
            chk("prio_count", i, int'(cnt_o[i]), 0);
            chk("prio_ovf", i, int'(ovf_o[i]), 0);
        end
        clr = 1'b0;
        cyc();
        chk("clamp100", 1, int'(cnt_o[1]), 99);
        chk("clamp_tc", 1, int'(tc_o[1]), 0);
        chk("clamp10", 0, int'(cnt_o[0]), 9);
        chk("clamp256", 3, int'(cnt_o[3]), 200);
        load = 1'b0;
        en = 1'b0;

        clr = 1'b1;
        cyc();
        clr = 1'b0;
        en = 1'b1;
        dir = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            chk("ps_count", k, int'(cnt_o[2]), k / 4);
        end
        en = 1'b0;
        cyc();
        cyc();
        en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk("ps_gap", k, int'(cnt_o[2]), (k == 4) ? 4 : 3);
        end
        cyc();
        cyc();
        load = 1'b1;
        ld_val = 8'd7;
        cyc();
        load = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk("ps_load", k, int'(cnt_o[2]), (k == 4) ? 8 : 7);
        end

        load = 1'b1;
        ld_val = 8'd5;
        cyc();
        load = 1'b0;
        for (int k = 0; k < 6; k++) begin
            dir = (k % 2 == 0);
            cyc();
            chk("flip_count", k, int'(cnt_o[0]), (k % 2 == 0) ? 6 : 5);
            chk("flip_tc", k, int'(tc_o[0]), 0);
        end

        clr = 1'b1;
        cyc();
        clr = 1'b0;
        dir = 1'b1;
        cyc();
        cyc();
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        compare_all();
        chk("async_count", 0, int'(cnt_o[0]), 0);
        chk("async_zero", 0, int'(zero_o[0]), 1);
        cyc();
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk("rst_ps", k, int'(cnt_o[2]), (k == 4) ? 1 : 0);
        end
        chk("rst_run", 0, int'(cnt_o[0]), 4);

        for (int n = 0; n < 3000; n++) begin
            clr = ($urandom_range(0, 79) == 0);
            load = ($urandom_range(0, 29) == 0);
            en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 47) == 0) dir = ~dir;
            ld_val = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 599) == 0) begin
                #2;
                rst_n = 1'b0;
                #1;
                compare_all();
                cyc();
                rst_n = 1'b1;
            end
            cyc();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
